data_sram_req_ctrl: RTL and testbench
=====================================

Name: data_sram_req_ctrl

Overview:
- Sits directly downstream of the store write-strobe generator, between the EX/MEM pipeline stages and the SRAM-like data bus.
- Latches one load/store request, including the byte strobe computed upstream, and drives the bus `req`/`addr_ok`/`data_ok` handshake.
- Holds the response until the MEM stage consumes it.
- Allows one outstanding transaction and handles pipeline flush (exception/eret) at every phase without corrupting bus protocol.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- req_valid  in  1  EX stage presents a memory op
- req_ready  out  1  block accepts op this cycle
- req_wr  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word (swl/swr sent as 2)
- req_addr  in  ADDR_W  byte address
- req_wstrb  in  DATA_W/8  byte strobe from strobe generator
- req_wdata  in  DATA_W  lane-aligned store data
- flush  in  1  cancel all in-flight/pending work
- resp_valid  out  1  transaction complete, data held
- resp_rdata  out  DATA_W  load data (0 for stores)
- resp_ready  in  1  MEM stage consumes response
- busy  out  1  state != IDLE
- data_sram_req  out  1  bus request
- data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata  out  1/2/ADDR_W/DATA_W/8/DATA_W  registered request fields
- data_sram_addr_ok  in  1  address phase accepted
- data_sram_data_ok  in  1  data phase complete
- data_sram_rdata  in  DATA_W  read data

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, resetn.
- Reset values: state=IDLE; cancel flag=0; all outputs 0.
- States:
  - IDLE
  - ADDR (req asserted)
  - WAIT (addr accepted, awaiting data_ok)
  - RESP (response held)
  - DROP (awaiting data_ok of a cancelled transaction)
- Accept rule: req_ready = !flush && (IDLE || (RESP && resp_ready)). Fire = req_valid && req_ready.
- Fire latches all req_* fields into the bus registers.
- Next state on fire is ADDR, except the local case below.
- Local store case: a store with req_wstrb==0 goes to RESP directly with resp_rdata=0. No bus transaction is issued.
- ADDR:
  - data_sram_req=1.
  - Bus fields stay stable until data_sram_addr_ok. Never withdraw req before addr_ok, even on flush.
  - On addr_ok: go to WAIT, or to DROP if the cancel flag is set or flush is asserted this cycle.
- WAIT: on data_ok, capture rdata (0 if store) and go to RESP; resp_valid=1 from the next cycle.
- RESP:
  - resp_valid=1; resp_rdata is stable.
  - On resp_ready: go to IDLE, or to ADDR if a new request fires the same cycle (back-to-back, zero bubble).
- Flush by state:
  - IDLE: no effect; nothing is accepted that cycle.
  - ADDR: set the cancel flag; stay in ADDR until addr_ok, then go to DROP.
  - WAIT: go to DROP. If data_ok arrives in the same cycle as flush, go to IDLE directly and discard the data.
  - RESP: go to IDLE; resp_valid deasserts the next cycle.
  - DROP: no additional effect.
- DROP: on data_ok go to IDLE. resp_valid stays 0 and the cancel flag clears.
- addr_ok and data_ok in the same cycle while in ADDR: treat as a complete transaction (go to RESP, or to IDLE if cancelled/flushed).
- data_ok outside WAIT/DROP/ADDR is ignored.
- Latency, zero-wait bus (addr_ok in the first ADDR cycle, data_ok the following cycle): fire at T, req high at T+1, data_ok at T+2, resp_valid at T+3.
- busy = (state != IDLE).

Test Plan:
- Word load, addr=0x1000_0004, addr_ok after 2 cycles, data_ok 1 cycle later with rdata=0xDEADBEEF -> req high for exactly 2 cycles with stable fields; resp_valid next cycle; resp_rdata=0xDEADBEEF; held until resp_ready.
- Byte store, addr offset 3, wstrb=4'b1000, wdata=0xAB000000 -> bus sees wr=1, size=0, wstrb=4'b1000; resp_valid with rdata=0.
- Store with wstrb=0 -> data_sram_req never asserts; resp_valid one cycle after fire.
- Flush in ADDR with addr_ok 3 cycles later -> req held until addr_ok; DROP until data_ok; resp_valid never asserts; back to IDLE, busy=0.
- Back-to-back: resp_ready together with req_valid in RESP -> new req on the next cycle, no idle gap; first response consumed exactly once.
- resetn asserted low in WAIT -> all outputs 0 immediately; a late data_ok after reset is ignored.

Source files
------------

// File: rtl/data_sram_req_ctrl.sv
// rtl/data_sram_req_ctrl.sv - single-outstanding load/store request controller for the SRAM-like data bus
// Holds one request on the bus, waits for data_ok, and keeps the response until MEM consumes it.
module data_sram_req_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wr,
   input  logic [1:0]          req_size,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic                flush,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   input  logic                resp_ready,
   output logic                busy,
   output logic                data_sram_req,
   output logic                data_sram_wr,
   output logic [1:0]          data_sram_size,
   output logic [ADDR_W-1:0]   data_sram_addr,
   output logic [DATA_W/8-1:0] data_sram_wstrb,
   output logic [DATA_W-1:0]   data_sram_wdata,
   input  logic                data_sram_addr_ok,
   input  logic                data_sram_data_ok,
   input  logic [DATA_W-1:0]   data_sram_rdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_RESP = 3'd3;
   localparam logic [2:0] S_DROP = 3'd4;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       cancel;
   logic       cancel_nxt;
   logic       capture;
   logic       fire;
   logic       local_store;

   // resetn gating keeps every output low while reset is held
   assign req_ready     = resetn && !flush &&
                          ((state == S_IDLE) || ((state == S_RESP) && resp_ready));
   assign fire          = req_valid && req_ready;
   assign local_store   = req_wr && (req_wstrb == '0);
   assign data_sram_req = (state == S_ADDR);
   assign resp_valid    = (state == S_RESP);
   assign busy          = (state != S_IDLE);

   always_comb begin
      state_nxt  = state;
      cancel_nxt = cancel;
      capture    = 1'b0;
      case (state)
         S_IDLE: begin
            if (fire) state_nxt = local_store ? S_RESP : S_ADDR;
         end
         S_ADDR: begin
            // req is never withdrawn before addr_ok; a flush only marks the op as cancelled
            if (data_sram_addr_ok) begin
               if (cancel || flush) begin
                  state_nxt  = data_sram_data_ok ? S_IDLE : S_DROP;
                  cancel_nxt = !data_sram_data_ok;
               end else if (data_sram_data_ok) begin
                  state_nxt = S_RESP;
                  capture   = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
               end
            end else if (flush) begin
               cancel_nxt = 1'b1;
            end
         end
         S_WAIT: begin
            if (data_sram_data_ok) begin
               if (flush) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_RESP;
                  capture   = 1'b1;
               end
            end else if (flush) begin
               state_nxt  = S_DROP;
               cancel_nxt = 1'b1;
            end
         end
         S_RESP: begin
            if (flush) begin
               state_nxt = S_IDLE;
            end else if (resp_ready) begin
               if (fire) state_nxt = local_store ? S_RESP : S_ADDR;
               else      state_nxt = S_IDLE;
            end
         end
         S_DROP: begin
            if (data_sram_data_ok) begin
               state_nxt  = S_IDLE;
               cancel_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            cancel_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= S_IDLE;
         cancel          <= 1'b0;
         resp_rdata      <= '0;
         data_sram_wr    <= 1'b0;
         data_sram_size  <= '0;
         data_sram_addr  <= '0;
         data_sram_wstrb <= '0;
         data_sram_wdata <= '0;
      end else begin
         state  <= state_nxt;
         cancel <= cancel_nxt;
         if (fire) begin
            data_sram_wr    <= req_wr;
            data_sram_size  <= req_size;
            data_sram_addr  <= req_addr;
            data_sram_wstrb <= req_wstrb;
            data_sram_wdata <= req_wdata;
         end
         if (capture) begin
            resp_rdata <= data_sram_wr ? '0 : data_sram_rdata;
         end else if (fire && local_store) begin
            resp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_data_sram_req_ctrl.sv
// tb/tb_data_sram_req_ctrl.sv - randomized scoreboard bench for data_sram_req_ctrl
// A transaction-level model predicts bus and response behaviour; a monitor checks responses.
module tb_data_sram_req_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [1:0]  req_size = '0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_wstrb = '0;
   logic [31:0] req_wdata = '0;
   logic        flush = 1'b0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_ready = 1'b0;
   logic        busy;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok = 1'b0;
   logic        data_sram_data_ok = 1'b0;
   logic [31:0] data_sram_rdata = '0;

   always #5 clk = ~clk;

   data_sram_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_size(req_size), .req_addr(req_addr), .req_wstrb(req_wstrb),
      .req_wdata(req_wdata), .flush(flush),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ready(resp_ready),
      .busy(busy), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   bit run_mon = 1'b0;

   // transaction-level model: outstanding bus op, its address phase, cancellation, held response
   bit m_out = 1'b0;
   bit m_apend = 1'b0;
   bit m_kill = 1'b0;
   bit m_resp = 1'b0;
   logic [70:0] cur = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return {req_ready, resp_valid, resp_rdata, busy, data_sram_req, data_sram_wr,
              data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (run_mon && resetn && resp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected actual=%0h required=none", resp_rdata);
            end else begin
               chk("resp_rdata", resp_rdata, exp_q[0]);
               if (resp_ready || flush) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step(input bit allow);
      bit exp_ready, fire, accepted, new_resp;
      @(negedge clk);
      chk("data_sram_req", data_sram_req, m_apend);
      chk("resp_valid", resp_valid, m_resp);
      chk("busy", busy, m_out || m_resp);
      if (m_apend)
         chk("bus_fields", {data_sram_wr, data_sram_size, data_sram_addr,
                            data_sram_wstrb, data_sram_wdata}, cur);
      flush      = allow && ($urandom_range(0, 11) == 0);
      req_valid  = allow && ($urandom_range(0, 1) == 1);
      req_wr     = ($urandom_range(0, 1) == 1);
      req_size   = 2'($urandom_range(0, 2));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_wstrb  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      resp_ready = !allow || ($urandom_range(0, 2) != 0);
      data_sram_rdata   = $urandom;
      data_sram_addr_ok = m_apend && ($urandom_range(0, 1) == 1);
      if (m_out && !m_apend)      data_sram_data_ok = ($urandom_range(0, 1) == 1);
      else if (data_sram_addr_ok) data_sram_data_ok = ($urandom_range(0, 2) == 0);
      else if (!m_out)            data_sram_data_ok = ($urandom_range(0, 7) == 0);
      else                        data_sram_data_ok = 1'b0;
      exp_ready = !flush && ((!m_out && !m_resp) || (m_resp && resp_ready));
      #1;
      chk("req_ready", req_ready, exp_ready);
      fire     = req_valid && exp_ready;
      new_resp = m_resp && !(flush || resp_ready);
      if (m_out) begin
         if (flush) m_kill = 1'b1;
         accepted = !m_apend || data_sram_addr_ok;
         if (data_sram_addr_ok) m_apend = 1'b0;
         if (accepted && data_sram_data_ok) begin
            m_out = 1'b0;
            if (!m_kill) begin
               exp_q.push_back(cur[70] ? 32'h0 : data_sram_rdata);
               new_resp = 1'b1;
            end
         end
      end
      if (fire) begin
         cur = {req_wr, req_size, req_addr, req_wstrb, req_wdata};
         if (req_wr && req_wstrb == 4'h0) begin
            exp_q.push_back(32'h0);
            new_resp = 1'b1;
         end else begin
            m_out   = 1'b1;
            m_apend = 1'b1;
            m_kill  = 1'b0;
         end
      end
      m_resp = new_resp;
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("reset_outputs", all_outs(), 128'h0);
      resetn  = 1'b1;
      run_mon = 1'b1;
      for (int i = 0; i < 3000; i++) step(1'b1);
      n = 0;
      while ((m_out || m_resp) && n < 200) begin
         step(1'b0);
         n++;
      end
      chk("drain_done", {m_out, m_resp}, 2'b00);
      @(negedge clk);
      chk("drain_idle", {busy, resp_valid, data_sram_req}, 3'b000);
      chk("queue_empty", exp_q.size(), 0);

      // reset asserted while a load waits for data_ok, then a late data_ok
      flush = 1'b0; resp_ready = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h1000_0004; req_wstrb = 4'hf;
      @(negedge clk);
      req_valid = 1'b0; data_sram_addr_ok = 1'b1;
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      chk("wait_busy", {busy, data_sram_req}, 2'b10);
      #2 resetn = 1'b0;
      #1 chk("async_reset_outputs", all_outs(), 128'h0);
      @(negedge clk);
      resetn = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      chk("late_data_ok_ignored", {busy, resp_valid, data_sram_req}, 3'b000);
      @(negedge clk);
      chk("still_idle", {busy, resp_valid, req_ready}, 3'b001);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
